// File: rtl/imm_split9.sv
// imm_split9: splits a 16-bit constant into one or two 9-bit immediate beats (load-high, then add-immediate).
// Optional split statistics counter enabled by defining IMM_SPLIT_STATS_EN.
module imm_split9 #(
    parameter int IN_W  = 16,
    parameter int IMM_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_kind,
    output logic             out_last
`ifdef IMM_SPLIT_STATS_EN
    ,
    output logic [15:0]      split_count
`endif
);

    localparam int HI_W = IN_W - IMM_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_HI = 2'd1,
        EMIT_LO = 2'd2
    } state_t;

    // A value fits when sign-extending its low IMM_W bits reproduces it exactly.
    function automatic logic fits_imm(input logic [IN_W-1:0] v);
        logic signed [IMM_W-1:0] lo_s;
        logic signed [IN_W-1:0]  ext_s;
        lo_s  = v[IMM_W-1:0];
        ext_s = IN_W'(lo_s);
        return ext_s == signed'(v);
    endfunction

    // High part biased by half an immediate so the signed low beat corrects it; wraps mod 2^IN_W.
    function automatic logic [HI_W-1:0] hi_part(input logic [IN_W-1:0] v);
        return HI_W'((v + IN_W'(1 << (IMM_W - 1))) >> IMM_W);
    endfunction

    state_t           state;
    logic [IMM_W-1:0] lo_hold;

    logic             accept;
    logic             beat_done;
    logic             ld_fits;
    logic [IMM_W-1:0] ld_lo;
    logic [HI_W-1:0]  ld_hi;

    assign in_ready  = (state == IDLE) || ((state == EMIT_LO) && out_ready);
    assign accept    = in_valid && in_ready;
    assign beat_done = out_valid && out_ready;

    always_comb begin
        ld_fits = fits_imm(in_data);
        ld_lo   = in_data[IMM_W-1:0];
        ld_hi   = hi_part(in_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_kind  <= 1'b0;
            out_last  <= 1'b0;
            lo_hold   <= '0;
        end else begin
            if (accept) begin
                // New constant: either a single low beat or a high beat with the low part parked.
                out_valid <= 1'b1;
                if (ld_fits) begin
                    state    <= EMIT_LO;
                    out_imm  <= ld_lo;
                    out_kind <= 1'b0;
                    out_last <= 1'b1;
                end else begin
                    state    <= EMIT_HI;
                    out_imm  <= IMM_W'(ld_hi);
                    out_kind <= 1'b1;
                    out_last <= 1'b0;
                    lo_hold  <= ld_lo;
                end
            end else if (beat_done) begin
                if (state == EMIT_HI) begin
                    state    <= EMIT_LO;
                    out_imm  <= lo_hold;
                    out_kind <= 1'b0;
                    out_last <= 1'b1;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            end
        end
    end

`ifdef IMM_SPLIT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_count <= '0;
        end else if (accept && !ld_fits && (split_count != 16'hFFFF)) begin
            split_count <= split_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_split9.sv
// Scoreboard bench for imm_split9: directed constants push hand-computed beats, a monitor pops and compares.
module tb_imm_split9;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [15:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_imm;
    logic       out_kind;
    logic       out_last;
`ifdef IMM_SPLIT_STATS_EN
    logic [15:0] split_count;
`endif

    imm_split9 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_kind  (out_kind),
        .out_last  (out_last)
`ifdef IMM_SPLIT_STATS_EN
        ,
        .split_count (split_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [10:0] exp_q[$];   // {imm, kind, last}
    int beat_log[$];
    logic acc_busy;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every completed beat against the scoreboard head.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                beat_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {21'd0, out_imm, out_kind, out_last}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {21'd0, out_imm, out_kind, out_last}, {21'd0, e});
                end
            end
        end
    end

    task automatic offer(input logic [15:0] d);
        int n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        acc_busy = out_valid && !out_kind && out_last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [15:0] d, input logic [8:0] imm);
        exp_q.push_back({imm, 1'b0, 1'b1});
        offer(d);
    endtask

    task automatic send2(input logic [15:0] d, input logic [8:0] hi, input logic [8:0] lo);
        exp_q.push_back({hi, 1'b1, 1'b0});
        exp_q.push_back({lo, 1'b0, 1'b1});
        offer(d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        acc_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_fields", {21'd0, out_imm, out_kind, out_last}, 32'd0);
`ifdef IMM_SPLIT_STATS_EN
        chk("rst_split_count", {16'd0, split_count}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // Single beats at both ends of the signed range.
        send1(16'h00FF, 9'h0FF);
        drain();
        chk("idle_after_single", {30'd0, out_valid, in_ready}, 32'd1);
        send1(16'hFF00, 9'h100);
        drain();

        // Smallest positive value that needs a split.
        send2(16'h0100, 9'h001, 9'h100);
        drain();

        // Back-to-back splits with no gap.
        beat_log.delete();
        send2(16'h7FFF, 9'h040, 9'h1FF);
        send2(16'h8000, 9'h040, 9'h000);
        chk("accept_during_lo_beat", {31'd0, acc_busy}, 32'd1);
        drain();
        chk("b2b_beat_count", beat_log.size(), 32'd4);
        if (beat_log.size() == 4)
            chk("b2b_no_gap", beat_log[3] - beat_log[0], 32'd3);

        // Backpressure on the high beat.
        out_ready = 1'b0;
        send2(16'h1234, 9'h009, 9'h034);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_hi", {19'd0, out_valid, in_ready, out_imm, out_kind, out_last},
                {19'd0, 1'b1, 1'b0, 9'h009, 1'b1, 1'b0});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
`ifdef IMM_SPLIT_STATS_EN
        chk("split_count_4", {16'd0, split_count}, 32'd4);
`endif

        // Asynchronous reset mid-sequence discards the pending beats.
        out_ready = 1'b0;
        send2(16'h1234, 9'h009, 9'h034);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef IMM_SPLIT_STATS_EN
        chk("rst_mid_split_count", {16'd0, split_count}, 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send1(16'h0005, 9'h005);
        drain();
        chk("idle_at_end", {30'd0, out_valid, in_ready}, 32'd1);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
